// File: rtl/game_tick_pkg.sv
// Shared constants for the game timebase.
// Contents:
//   MODE_*    2-bit channel mode encodings (off, strobe, toggle, one-shot)
//   CLK_HZ    board clock frequency
//   HALF_SEC  clock cycles in half a second (default channel period)
//   arm_ok    decides whether a channel with a given mode/period counts at all
package game_tick_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_STROBE  = 2'b01;
  localparam logic [1:0] MODE_TOGGLE  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned HALF_SEC = 25_000_000;

  // A zero period is treated exactly like off: never armed, never fires.
  function automatic logic arm_ok(input logic [1:0] mode, input logic period_nz);
    return (mode != MODE_OFF) && period_nz;
  endfunction

endpackage

// File: rtl/game_tick_channel.sv
// One timebase channel: period/mode registers, counter and event flops.
// Ports:
//   clk, resetn           board clock, async active-low reset
//   enable                run; low pauses the counter (tick forced low)
//   clear                 restart this channel with its current settings
//   load                  load load_period/load_mode and restart
//   load_period [CNT_W]   new period P
//   load_mode   [2]       new mode
//   tick, level, busy     registered outputs
module game_tick_channel
  import game_tick_pkg::*;
#(
  parameter int          CNT_W          = 27,
  parameter int unsigned DEFAULT_PERIOD = HALF_SEC,
  parameter logic [1:0]  DEFAULT_MODE   = MODE_TOGGLE
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  input  logic [1:0]       load_mode,
  output logic             tick,
  output logic             level,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic             RST_BUSY   = (DEFAULT_MODE != MODE_OFF) && (DEFAULT_PERIOD != 0);

  logic [CNT_W-1:0] period_q, period_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] period_m1;

  // Only meaningful while busy, which implies a non-zero period.
  assign period_m1 = period_q - CNT_W'(1);

  always_comb begin
    period_d = period_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    level_d  = level_q;
    busy_d   = busy_q;
    if (load || clear) begin
      // Restart beats any terminal count this cycle, so no event escapes.
      if (load) begin
        period_d = load_period;
        mode_d   = load_mode;
      end
      cnt_d   = '0;
      level_d = 1'b0;
      busy_d  = arm_ok(mode_d, period_d != '0);
    end else if (mode_q == MODE_OFF) begin
      cnt_d = '0;
    end else if (busy_q && enable) begin
      if (cnt_q == period_m1) begin
        cnt_d = '0;
        case (mode_q)
          MODE_STROBE:  tick_d = 1'b1;
          MODE_TOGGLE:  level_d = ~level_q;
          MODE_ONESHOT: begin
            tick_d = 1'b1;
            busy_d = 1'b0;
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_q <= RST_PERIOD;
      mode_q   <= DEFAULT_MODE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      level_q  <= 1'b0;
      busy_q   <= RST_BUSY;
    end else begin
      period_q <= period_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
    end
  end

  assign tick  = tick_q;
  assign level = level_q;
  assign busy  = busy_q;

endmodule

// File: rtl/game_tick_gen.sv
// Multi-channel timebase for game logic.
// Ports:
//   clk, resetn         board clock, async active-low reset
//   enable              global run/pause
//   clear               synchronous restart of all channels
//   cfg_we, cfg_ch      configuration write strobe and target channel
//   cfg_period, cfg_mode  settings written on cfg_we
//   tick  [NUM_CH]      one-cycle event pulses (strobe / one-shot)
//   level [NUM_CH]      square-wave outputs (toggle)
//   busy  [NUM_CH]      channel armed and counting
module game_tick_gen
  import game_tick_pkg::*;
#(
  parameter int          CNT_W          = 27,
  parameter int          NUM_CH         = 4,
  parameter int unsigned DEFAULT_PERIOD = HALF_SEC,
  parameter logic [1:0]  DEFAULT_MODE   = MODE_TOGGLE,
  localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              clear,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [1:0]        cfg_mode,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] busy
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic load;

    // Out-of-range channel numbers match no instance and are dropped.
    assign load = cfg_we && (cfg_ch == CH_W'(gi));

    game_tick_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .DEFAULT_MODE   (DEFAULT_MODE)
    ) u_ch (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable),
      .clear       (clear),
      .load        (load),
      .load_period (cfg_period),
      .load_mode   (cfg_mode),
      .tick        (tick[gi]),
      .level       (level[gi]),
      .busy        (busy[gi])
    );
  end

endmodule

// File: tb/tb_game_tick_gen.sv
module tb_game_tick_gen;

  localparam int CNT_W  = 27;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b1;
  logic              clear = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [1:0]        cfg_mode = '0;
  logic [NUM_CH-1:0] tick, level, busy;

  game_tick_gen #(
    .CNT_W          (CNT_W),
    .NUM_CH         (NUM_CH),
    .DEFAULT_PERIOD (10),
    .DEFAULT_MODE   (2'b10)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .clear      (clear),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_mode   (cfg_mode),
    .tick       (tick),
    .level      (level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Rising-edge count; expectations are keyed by the edge they follow.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int    cyc;
    int    ch;
    logic  t;
    logic  l;
    logic  b;
    string name;
  } exp_t;

  exp_t sb_q[$];
  exp_t keep_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic exp_at(input int cyc, input int ch, input logic t, input logic l,
                        input logic b, input string name);
    exp_t e;
    e.cyc = cyc; e.ch = ch; e.t = t; e.l = l; e.b = b; e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: after every rising edge, pop and compare due expectations.
  always @(negedge clk) begin
    keep_q = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc == edge_n) begin
        n_vec++;
        if ({tick[sb_q[i].ch], level[sb_q[i].ch], busy[sb_q[i].ch]} !== {sb_q[i].t, sb_q[i].l, sb_q[i].b}) begin
          n_bad++;
          $display("FAIL %s edge %0d ch%0d: tick/level/busy got %b%b%b want %b%b%b",
                   sb_q[i].name, edge_n, sb_q[i].ch, tick[sb_q[i].ch], level[sb_q[i].ch],
                   busy[sb_q[i].ch], sb_q[i].t, sb_q[i].l, sb_q[i].b);
        end else begin
          $display("ok   %s edge %0d ch%0d tick/level/busy=%b%b%b", sb_q[i].name, edge_n,
                   sb_q[i].ch, tick[sb_q[i].ch], level[sb_q[i].ch], busy[sb_q[i].ch]);
        end
      end else if (sb_q[i].cyc < edge_n) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s expired: edge %0d passed, now %0d", sb_q[i].name, sb_q[i].cyc, edge_n);
      end else begin
        keep_q.push_back(sb_q[i]);
      end
    end
    sb_q = keep_q;
  end

  // Return 1 ns after rising edge k has been taken.
  task automatic wait_edge(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input int ch, input int p, input logic [1:0] m);
    cfg_we = 1'b1;
    cfg_ch = CH_W'(ch);
    cfg_period = CNT_W'(p);
    cfg_mode = m;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    // Reset defaults: P=10 toggle, events 10 edges after release (edge 3).
    exp_at(1, 0, 0, 0, 1, "rst_ch0");
    exp_at(2, 1, 0, 0, 1, "rst_ch1");
    exp_at(2, 2, 0, 0, 1, "rst_ch2");
    exp_at(12, 0, 0, 0, 1, "dflt_pre");
    exp_at(13, 0, 0, 1, 1, "dflt_tog1");
    exp_at(13, 2, 0, 1, 1, "dflt_tog1_ch2");
    exp_at(22, 0, 0, 1, 1, "dflt_hold");
    exp_at(23, 0, 0, 0, 1, "dflt_tog2");
    exp_at(33, 0, 0, 1, 1, "dflt_tog3");
    wait_edge(3);
    resetn = 1'b1;

    // Strobe on ch1, written at edge 36.
    exp_at(36, 1, 0, 0, 1, "strb_arm");
    exp_at(40, 1, 0, 0, 1, "strb_pre");
    exp_at(41, 1, 1, 0, 1, "strb_t1");
    exp_at(42, 1, 0, 0, 1, "strb_t1_end");
    exp_at(42, 0, 0, 1, 1, "strb_ch0_keep");
    exp_at(43, 0, 0, 0, 1, "strb_ch0_tog");
    exp_at(46, 1, 1, 0, 1, "strb_t2");
    exp_at(51, 1, 1, 0, 1, "strb_t3");
    wait_edge(35);
    cfg_write(1, 5, 2'b01);

    // Pause edges 54..56 at count 2: ch1 tick 56->59, ch0 toggle 63->66.
    exp_at(55, 1, 0, 0, 1, "pause_tick0");
    exp_at(56, 1, 0, 0, 1, "pause_no_tick");
    exp_at(58, 1, 0, 0, 1, "pause_pre");
    exp_at(59, 1, 1, 0, 1, "pause_tick");
    exp_at(63, 0, 0, 1, 1, "pause_lvl_hold");
    exp_at(66, 0, 0, 0, 1, "pause_lvl_tog");
    wait_edge(53);
    enable = 1'b0;
    wait_edge(56);
    enable = 1'b1;

    // One-shot on ch2, written at edge 61; clear at edge 87 re-arms.
    exp_at(64, 2, 0, 0, 1, "os_pre");
    exp_at(65, 2, 1, 0, 0, "os_fire");
    exp_at(66, 2, 0, 0, 0, "os_end");
    exp_at(75, 2, 0, 0, 0, "os_quiet1");
    exp_at(85, 2, 0, 0, 0, "os_quiet2");
    exp_at(87, 2, 0, 0, 1, "clr_rearm");
    exp_at(87, 0, 0, 0, 1, "clr_ch0");
    exp_at(90, 2, 0, 0, 1, "clr_pre");
    exp_at(91, 2, 1, 0, 0, "clr_fire");
    exp_at(91, 1, 0, 0, 1, "clr_ch1_pre");
    exp_at(92, 1, 1, 0, 1, "clr_ch1_tick");
    exp_at(97, 0, 0, 1, 1, "clr_ch0_tog");
    wait_edge(60);
    cfg_write(2, 4, 2'b11);
    wait_edge(86);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;

    // Write to ch1 on its terminal-count edge 102: no tick, restart.
    exp_at(102, 1, 0, 0, 1, "coll_no_tick");
    exp_at(106, 1, 0, 0, 1, "coll_pre");
    exp_at(107, 1, 1, 0, 1, "coll_tick");
    wait_edge(101);
    cfg_write(1, 5, 2'b01);

    // Out-of-range channel 3 written at edge 109: nothing changes.
    exp_at(110, 2, 0, 0, 0, "oor_ch2");
    exp_at(111, 1, 0, 0, 1, "oor_ch1_pre");
    exp_at(112, 1, 1, 0, 1, "oor_ch1_tick");
    exp_at(116, 0, 0, 0, 1, "oor_ch0_keep");
    exp_at(117, 0, 0, 1, 1, "oor_ch0_tog");
    wait_edge(108);
    cfg_write(3, 1, 2'b01);

    // P=0 on ch2 at edge 119: idle.
    exp_at(119, 2, 0, 0, 0, "p0_arm");
    exp_at(125, 2, 0, 0, 0, "p0_quiet");
    wait_edge(118);
    cfg_write(2, 0, 2'b01);

    // P=1 strobe on ch0 at edge 127: tick stays high.
    exp_at(127, 0, 0, 0, 1, "p1s_arm");
    exp_at(128, 0, 1, 0, 1, "p1s_t1");
    exp_at(129, 0, 1, 0, 1, "p1s_t2");
    exp_at(130, 0, 1, 0, 1, "p1s_t3");
    wait_edge(126);
    cfg_write(0, 1, 2'b01);

    // P=1 toggle on ch2 at edge 132: level flips every edge.
    exp_at(132, 2, 0, 0, 1, "p1t_arm");
    exp_at(133, 2, 0, 1, 1, "p1t_l1");
    exp_at(134, 2, 0, 0, 1, "p1t_l2");
    wait_edge(131);
    cfg_write(2, 1, 2'b10);

    // Async reset between edges 135 and 136 (ch1 cnt=3), released after 137.
    exp_at(135, 0, 0, 0, 1, "arst_ch0");
    exp_at(135, 1, 0, 0, 1, "arst_ch1");
    exp_at(135, 2, 0, 0, 1, "arst_ch2");
    exp_at(136, 0, 0, 0, 1, "arst_hold");
    exp_at(146, 1, 0, 0, 1, "arst_pre");
    exp_at(147, 1, 0, 1, 1, "arst_tog_ch1");
    exp_at(147, 0, 0, 1, 1, "arst_tog_ch0");
    wait_edge(135);
    #2;
    resetn = 1'b0;
    wait_edge(137);
    resetn = 1'b1;

    wait_edge(150);
    @(negedge clk);
    #1;
    foreach (sb_q[i]) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s never checked (edge %0d)", sb_q[i].name, sb_q[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/game_tick_gen.md
# game_tick_gen

Parametrised multi-channel timebase for game logic on the 50 MHz board clock. Each of NUM_CH channels has its own run-time programmable period and mode: periodic one-cycle strobe, square-wave toggle, or one-shot. It sits between the board clock and the game FSMs, sprite movers and animation counters that need slow, regular events. Out of reset every channel toggles its level output every half second.

## Interface
- CNT_W, 27, counter and period width in bits.
- NUM_CH, 4, number of independent channels (≥1).
- DEFAULT_PERIOD, 25_000_000, per-channel period after reset (must fit in CNT_W).
- DEFAULT_MODE, 2'b10, per-channel mode after reset (toggle).
- clk  in  1  board clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  global run; low pauses all channels.
- clear  in  1  synchronous restart of all channels.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel selected by cfg_we.
- cfg_period  in  CNT_W  period P in clk cycles.
- cfg_mode  in  2  00 off, 01 strobe, 10 toggle, 11 one-shot.
- tick  out  NUM_CH  one-cycle event pulse per channel (strobe and one-shot modes).
- level  out  NUM_CH  square-wave output per channel (toggle mode).
- busy  out  NUM_CH  channel is armed and counting.

## Operation
- Per-channel state: period register, mode register, counter cnt, tick, level and busy flops.
- Reset (async, resetn=0): period=DEFAULT_PERIOD, mode=DEFAULT_MODE, cnt=0, tick=0, level=0, busy=1 if mode≠off and period≠0, else 0.
- Terminal count: cnt==P-1 with busy=1 and enable=1. At that edge cnt←0 and:
  - strobe: tick←1.
  - toggle: level←~level.
  - one-shot: tick←1, busy←0.
- Otherwise, with busy=1 and enable=1: cnt←cnt+1, tick←0.
- enable=0: cnt, level and busy hold; tick←0. This is a pause, not a clear.
- Period and mode rules:
  - P=0 behaves as off (busy=0, no events).
  - P=1 strobe holds tick high every cycle.
  - P=1 toggle flips level every cycle.
- Off mode: cnt=0, tick=0; level holds its last value.
- cfg_we=1: the selected channel loads period and mode, then cnt←0, tick←0, level←0, busy←(mode≠off && P≠0).
  - A write wins over a terminal count on that channel in the same cycle: no event is produced.
  - cfg_ch≥NUM_CH is ignored.
- clear=1: every channel gets cnt←0, tick←0, level←0, busy←(mode≠off && P≠0). This re-arms one-shots that have fired.
- clear and cfg_we in the same cycle: both apply. The written channel uses the new period and mode.
- clear has priority over enable. clear works while enable=0.
- Arithmetic: unsigned CNT_W compare against P-1. cnt never exceeds P-1, so there is no wrap beyond the terminal count.

## Timing
- Outputs are registered; there are no combinational input-to-output paths.
- Event latency: with enable held high from an arm edge (reset release, cfg write or clear), the first event is visible after exactly P rising edges, then every P edges.
- One-shot: one tick, P edges after arm. busy falls on the same edge the tick rises.
- Pause: deasserting enable for N cycles delays all subsequent events by exactly N cycles.
- Config write: new settings take effect on the edge after cfg_we is sampled. The counter restarts from 0 at that edge.
- Reset mid-count: all outputs take their reset values immediately, asynchronously. Counting resumes on the first edge after resetn rises.

## Structure
- Package game_tick_pkg:
  - mode constants MODE_OFF, MODE_STROBE, MODE_TOGGLE, MODE_ONESHOT (2-bit).
  - default constants CLK_HZ=50_000_000 and HALF_SEC=25_000_000.
- Sub-module game_tick_channel holds one channel: period/mode registers, counter, tick/level/busy logic. It takes a local load strobe, clear and enable.
- Top game_tick_gen decodes cfg_ch into per-channel load strobes and instantiates NUM_CH channels with a generate loop.

## Test plan
- Reset defaults: use DEFAULT_PERIOD=10 in the bench, hold enable=1 → level[0] toggles at edges 10, 20, 30; tick stays 0; busy=1 on all channels.
- Strobe: write ch1 P=5, mode 01 → tick[1] is high for one cycle at edges 5, 10, 15 after the write; other channels are unaffected.
- Pause: strobe P=5, drop enable for 3 cycles at count 2 → next tick arrives at edge 8 instead of 5; level and cnt hold during the pause.
- One-shot and re-arm: write ch2 P=4, mode 11 → single tick at edge 4 and busy[2]→0; no further ticks for 20 cycles; pulse clear → tick again 4 edges later.
- Collisions:
  - cfg_we on ch1 in the same cycle as its terminal count → no tick, counter restarts.
  - cfg_ch=NUM_CH → no channel changes.
  - P=0 → busy=0, silent.
  - P=1 strobe → tick high continuously.
- Async reset mid-count: assert resetn=0 between edges at cnt=3 → outputs clear immediately; first event comes exactly P edges after release.
